// File: rtl/r4booth_pkg.sv
// Shared definitions for the radix-4 Booth multiplier: digit encoding, digit
// decoder and the row-count formula used to size the pipeline.
package r4booth_pkg;

  typedef enum logic [2:0] {
    DIG_ZERO = 3'd0,
    DIG_POS1 = 3'd1,
    DIG_POS2 = 3'd2,
    DIG_NEG1 = 3'd3,
    DIG_NEG2 = 3'd4
  } booth_digit_e;

  // One Booth digit per two multiplier bits, plus one to absorb the extension bits.
  function automatic int unsigned booth_rows(input int unsigned n);
    return (n / 32'd2) + 32'd1;
  endfunction

  function automatic booth_digit_e booth_decode(input logic [2:0] bits);
    booth_digit_e dig;
    case (bits)
      3'b000:  dig = DIG_ZERO;
      3'b001:  dig = DIG_POS1;
      3'b010:  dig = DIG_POS1;
      3'b011:  dig = DIG_POS2;
      3'b100:  dig = DIG_NEG2;
      3'b101:  dig = DIG_NEG1;
      3'b110:  dig = DIG_NEG1;
      3'b111:  dig = DIG_ZERO;
      default: dig = DIG_ZERO;
    endcase
    return dig;
  endfunction

endpackage

// File: rtl/r4booth_row.sv
// One Booth partial-product row: selects 0/+-A/+-2A from the digit, sign-extends
// to 2N bits and applies the row's 2*IDX weight.
module r4booth_row
  import r4booth_pkg::*;
#(
  parameter int N   = 16,
  parameter int IDX = 0
) (
  input  logic [2:0]     digit,
  input  logic [N+1:0]   a_ext,
  output logic [2*N-1:0] pp
);

  localparam int W  = 2 * N;
  localparam int SH = 2 * IDX;
  localparam logic [W-1:0] ONE_W = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] a_sx_s;
  logic [W-1:0] a_x2_s;
  logic [W-1:0] sel_s;

  assign a_sx_s = {{(W-N-2){a_ext[N+1]}}, a_ext};
  assign a_x2_s = {a_sx_s[W-2:0], 1'b0};

  // Digit-controlled multiple of A, negated in two's complement within 2N bits
  always_comb begin
    sel_s = {W{1'b0}};
    case (booth_digit_e'(digit))
      DIG_ZERO: sel_s = {W{1'b0}};
      DIG_POS1: sel_s = a_sx_s;
      DIG_POS2: sel_s = a_x2_s;
      DIG_NEG1: sel_s = ~a_sx_s + ONE_W;
      DIG_NEG2: sel_s = ~a_x2_s + ONE_W;
      default:  sel_s = {W{1'b0}};
    endcase
  end

  assign pp = sel_s << SH;

endmodule

// File: rtl/r4booth_pipe.sv
// Three-stage radix-4 Booth multiplier (rows, pair sums, final sum) with a
// single global advance enable for valid/ready backpressure; falling-edge clocked.
module r4booth_pipe
  import r4booth_pkg::*;
#(
  parameter int N = 16
) (
  input  logic           clkn_i,
  input  logic           rst_i,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic           signed_i,
  input  logic [N-1:0]   multiplicand_i,
  input  logic [N-1:0]   multiplier_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [2*N-1:0] product_o
);

  localparam int ROWS  = int'(booth_rows(N));
  localparam int PAIRS = (ROWS + 1) / 2;
  localparam int W     = 2 * N;

  logic           en_s;
  logic [N+1:0]   a_ext_s;
  logic [N+1:0]   b_ext_s;
  logic [N+2:0]   b_pad_s;
  logic [2:0]     digit_s [ROWS];
  logic [W-1:0]   row_s   [ROWS];
  logic [W-1:0]   pair_s  [PAIRS];
  logic [W-1:0]   acc_s;

  logic [W-1:0]   row_r   [ROWS];
  logic           v1_r;
  logic [W-1:0]   sum_r   [PAIRS];
  logic           v2_r;
  logic [W-1:0]   product_r;
  logic           out_valid_r;

  // The whole pipeline moves together; ready never depends on in_valid_i.
  assign en_s        = ~out_valid_r | out_ready_i;
  assign in_ready_o  = en_s;
  assign out_valid_o = out_valid_r;
  assign product_o   = product_r;

  // Extend operands by two bits so the top Booth digit sees the true sign
  always_comb begin
    a_ext_s = {2'b00, multiplicand_i};
    b_ext_s = {2'b00, multiplier_i};
    if (signed_i) begin
      a_ext_s = {{2{multiplicand_i[N-1]}}, multiplicand_i};
      b_ext_s = {{2{multiplier_i[N-1]}}, multiplier_i};
    end else begin
      a_ext_s = {2'b00, multiplicand_i};
      b_ext_s = {2'b00, multiplier_i};
    end
  end

  assign b_pad_s = {b_ext_s, 1'b0};

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    assign digit_s[gi] = booth_decode(b_pad_s[2*gi+2 -: 3]);

    r4booth_row #(
      .N   (N),
      .IDX (gi)
    ) u_row (
      .digit (digit_s[gi]),
      .a_ext (a_ext_s),
      .pp    (row_s[gi])
    );
  end

  // With odd ROWS the last row has no partner and passes straight through
  for (genvar gk = 0; gk < PAIRS; gk++) begin : g_pair
    if (2 * gk + 1 < ROWS) begin : g_two
      assign pair_s[gk] = row_r[2*gk] + row_r[2*gk+1];
    end else begin : g_one
      assign pair_s[gk] = row_r[2*gk];
    end
  end

  // Final modulo-2^2N accumulation of the pair sums
  always_comb begin
    acc_s = {W{1'b0}};
    for (int k = 0; k < PAIRS; k++) begin
      acc_s = acc_s + sum_r[k];
    end
  end

  // Stage 1: partial-product rows and transaction valid
  always_ff @(negedge clkn_i or posedge rst_i) begin
    if (rst_i) begin
      v1_r <= 1'b0;
      for (int i = 0; i < ROWS; i++) begin
        row_r[i] <= {W{1'b0}};
      end
    end else if (en_s) begin
      v1_r <= in_valid_i;
      for (int i = 0; i < ROWS; i++) begin
        row_r[i] <= row_s[i];
      end
    end
  end

  // Stage 2: pairwise reduction
  always_ff @(negedge clkn_i or posedge rst_i) begin
    if (rst_i) begin
      v2_r <= 1'b0;
      for (int k = 0; k < PAIRS; k++) begin
        sum_r[k] <= {W{1'b0}};
      end
    end else if (en_s) begin
      v2_r <= v1_r;
      for (int k = 0; k < PAIRS; k++) begin
        sum_r[k] <= pair_s[k];
      end
    end
  end

  // Stage 3: registered product and output valid
  always_ff @(negedge clkn_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_r <= 1'b0;
      product_r   <= {W{1'b0}};
    end else if (en_s) begin
      out_valid_r <= v2_r;
      product_r   <= acc_s;
    end
  end

endmodule

// File: tb/tb_r4booth_pipe.sv
// Bench for r4booth_pipe: directed tables at N=8 and N=7, plus a scoreboard
// driven by a plain-arithmetic product model for streaming and backpressure.
module tb_r4booth_pipe;

  logic clk;
  logic rst;

  logic        v8, s8, or8;
  logic [7:0]  a8, b8;
  logic        rdy8, ov8;
  logic [15:0] p8;

  logic        v7, s7, or7;
  logic [6:0]  a7, b7;
  logic        rdy7, ov7;
  logic [13:0] p7;

  r4booth_pipe #(.N(8)) u_dut8 (
    .clkn_i(clk), .rst_i(rst), .in_valid_i(v8), .in_ready_o(rdy8),
    .signed_i(s8), .multiplicand_i(a8), .multiplier_i(b8),
    .out_valid_o(ov8), .out_ready_i(or8), .product_o(p8)
  );

  r4booth_pipe #(.N(7)) u_dut7 (
    .clkn_i(clk), .rst_i(rst), .in_valid_i(v7), .in_ready_o(rdy7),
    .signed_i(s7), .multiplicand_i(a7), .multiplier_i(b7),
    .out_valid_o(ov7), .out_ready_i(or7), .product_o(p7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model8(input logic s, input logic [7:0] a, input logic [7:0] b);
    longint pa, pb;
    pa = s ? longint'($signed(a)) : longint'($unsigned(a));
    pb = s ? longint'($signed(b)) : longint'($unsigned(b));
    return 16'(pa * pb);
  endfunction

  function automatic logic [13:0] model7(input logic s, input logic [6:0] a, input logic [6:0] b);
    longint pa, pb;
    pa = s ? longint'($signed(a)) : longint'($unsigned(a));
    pb = s ? longint'($signed(b)) : longint'($unsigned(b));
    return 14'(pa * pb);
  endfunction

  function automatic logic [7:0] pick8();
    int unsigned r;
    r = $urandom_range(0, 7);
    case (r)
      0: return 8'h00;
      1: return 8'hFF;
      2: return 8'h80;
      3: return 8'h7F;
      default: return 8'($urandom);
    endcase
  endfunction

  // Scoreboard for the N=8 instance
  int          cyc = 0;
  logic [15:0] exp_q[$];
  int          pop_cyc[$];

  always @(negedge clk) cyc = cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (ov8 && or8) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected actual=0x%0h required=no result", p8);
        end else begin
          chk("sb_prod", longint'(p8), longint'(exp_q.pop_front()));
          pop_cyc.push_back(cyc);
        end
      end
      if (v8 && rdy8) exp_q.push_back(model8(s8, a8, b8));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic send8(input logic s, input logic [7:0] a, input logic [7:0] b);
    int n;
    @(posedge clk);
    v8 = 1'b1; s8 = s; a8 = a; b8 = b;
    #1;
    n = 0;
    while (!rdy8 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!rdy8) chk("send_ready", longint'(rdy8), 1);
  endtask

  task automatic single8(input logic s, input logic [7:0] a, input logic [7:0] b, input logic [15:0] e);
    int n;
    @(posedge clk);
    v8 = 1'b1; s8 = s; a8 = a; b8 = b;
    #1;
    chk("t8_ready", longint'(rdy8), 1);
    @(posedge clk);
    v8 = 1'b0;
    #1;
    n = 1;
    while (!ov8 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t8_latency", n, 3);
    chk("t8_prod", longint'(p8), longint'(e));
  endtask

  task automatic single7(input logic s, input logic [6:0] a, input logic [6:0] b, input logic [13:0] e);
    int n;
    @(posedge clk);
    v7 = 1'b1; s7 = s; a7 = a; b7 = b;
    @(posedge clk);
    v7 = 1'b0;
    #1;
    n = 1;
    while (!ov7 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t7_latency", n, 3);
    chk("t7_prod", longint'(p7), longint'(e));
  endtask

  typedef struct { logic s; logic [7:0] a; logic [7:0] b; logic [15:0] e; } vec8_t;
  typedef struct { logic s; logic [6:0] a; logic [6:0] b; logic [13:0] e; } vec7_t;

  initial begin
    vec8_t t8[6];
    vec7_t t7[4];
    logic [15:0] e1;
    logic [7:0]  ra, rb;
    logic        rs;
    bit          pend;
    int          bad;

    t8[0] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    t8[1] = '{1'b0, 8'h00, 8'd200, 16'h0000};
    t8[2] = '{1'b1, 8'h80, 8'h80, 16'h4000};
    t8[3] = '{1'b1, 8'h80, 8'h7F, 16'hC080};
    t8[4] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
    t8[5] = '{1'b0, 8'h80, 8'h80, 16'h4000};
    t7[0] = '{1'b0, 7'h7F, 7'h7F, 14'h3F01};
    t7[1] = '{1'b1, 7'h40, 7'h3F, 14'h3040};
    t7[2] = '{1'b1, 7'h40, 7'h40, 14'h1000};
    t7[3] = '{1'b0, 7'h7F, 7'h01, 14'h007F};

    rst = 1'b1;
    v8 = 1'b0; s8 = 1'b0; a8 = 8'h00; b8 = 8'h00; or8 = 1'b1;
    v7 = 1'b0; s7 = 1'b0; a7 = 7'h00; b7 = 7'h00; or7 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", longint'(ov8), 0);
    chk("rst_prod", longint'(p8), 0);
    @(posedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", longint'(rdy8), 1);

    for (int i = 0; i < 6; i++) single8(t8[i].s, t8[i].a, t8[i].b, t8[i].e);

    // signed then unsigned on consecutive cycles; scoreboard checks both
    send8(1'b1, 8'h80, 8'h80);
    send8(1'b0, 8'h80, 8'h80);
    @(posedge clk);
    v8 = 1'b0;
    repeat (5) @(posedge clk);

    for (int i = 0; i < 4; i++) single7(t7[i].s, t7[i].a, t7[i].b, t7[i].e);
    for (int i = 0; i < 10; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = 8'($urandom);
      rb = 8'($urandom);
      single7(rs, ra[6:0], rb[6:0], model7(rs, ra[6:0], rb[6:0]));
    end

    // back-to-back stream
    pop_cyc.delete();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      v8 = 1'b1; s8 = 1'($urandom_range(0, 1)); a8 = pick8(); b8 = pick8();
      #1;
      chk("b2b_ready", longint'(rdy8), 1);
    end
    @(posedge clk);
    v8 = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    chk("b2b_count", pop_cyc.size(), 10);
    bad = 0;
    for (int i = 1; i < pop_cyc.size(); i++) if (pop_cyc[i] - pop_cyc[i-1] != 1) bad++;
    chk("b2b_gaps", bad, 0);

    // backpressure: three fill the pipe, the fourth must wait
    @(posedge clk);
    or8 = 1'b0;
    e1 = model8(1'b0, 8'd17, 8'd23);
    send8(1'b0, 8'd17, 8'd23);
    send8(1'b1, 8'hF0, 8'h11);
    send8(1'b0, 8'hC3, 8'h5A);
    @(posedge clk);
    v8 = 1'b1; s8 = 1'b1; a8 = 8'h81; b8 = 8'h7E;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(posedge clk);
      #1;
      chk("bp_valid", longint'(ov8), 1);
      chk("bp_prod", longint'(p8), longint'(e1));
      chk("bp_ready", longint'(rdy8), 0);
    end
    @(posedge clk);
    or8 = 1'b1;
    @(posedge clk);
    v8 = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    chk("bp_drained", exp_q.size(), 0);

    // random valid/ready traffic, operands held while not accepted
    pend = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      if (!pend) begin
        v8 = 1'($urandom_range(0, 1)); s8 = 1'($urandom_range(0, 1));
        a8 = pick8(); b8 = pick8();
      end
      or8 = ($urandom_range(0, 3) != 0);
      #1;
      pend = v8 && !rdy8;
    end
    @(posedge clk);
    v8 = 1'b0; or8 = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    chk("rnd_drained", exp_q.size(), 0);

    // reset with transactions in flight
    send8(1'b0, 8'd9, 8'd9);
    send8(1'b0, 8'd10, 8'd10);
    send8(1'b0, 8'd11, 8'd11);
    @(posedge clk);
    v8 = 1'b0;
    #1;
    chk("mid_valid_pre", longint'(ov8), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", longint'(ov8), 0);
    chk("mid_rst_prod", longint'(p8), 0);
    repeat (2) @(posedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("mid_stale", longint'(ov8), 0);
      @(posedge clk);
    end
    single8(1'b0, 8'd3, 8'd5, 16'd15);
    repeat (3) @(posedge clk);
    #2;
    chk("final_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
